// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Read wait-state timer: done is high in the MEM_LAT-th cycle after a start pulse.
module mem_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int CW = ($clog2(MEM_LAT + 1) < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT);

    logic [CW-1:0] cnt;

    // cnt == 0 means idle; a start loads 1 so the count equals cycles elapsed.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(1);
        end else if (done) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the multicycle CPU's single memory port between fetch (IF) and load/store (LS).
// Optional misaligned-access trapping is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_ALIGN_CHECK_EN
    ,
    output logic              if_err,
    output logic              ls_err
`endif
);

    localparam int SW = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic [SW-1:0]     starve_cnt;
    logic              gnt_if_c, gnt_ls_c;
    logic              misalign;
    logic              wait_start, wait_done;

    // LS wins unless IF has been passed over STARVE_MAX times in a row.
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_ls_c = 1'b0;
        if (state == IDLE && !reset) begin
            if (if_req && (!ls_req || starve_cnt == STARVE_LIM)) begin
                gnt_if_c = 1'b1;
            end else if (ls_req) begin
                gnt_ls_c = 1'b1;
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic err_q;
    assign misalign = gnt_ls_c ? (ls_addr[1:0] != 2'b00) : (if_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign wait_start = (gnt_if_c || (gnt_ls_c && !ls_we)) && !misalign;

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clock (clock),
        .reset (reset),
        .start (wait_start),
        .done  (wait_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are gated by reset so an aborted access never shows mem_we or rvalid.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if_err    = 1'b0;
        ls_err    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gnt_if_c || gnt_ls_c) begin
                    if (misalign) begin
                        state_nxt = RESP;
                    end else if (gnt_ls_c && ls_we) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (wait_done) begin
                    state_nxt = RESP;
                end
            end
            WR: begin
                mem_we    = 1'b1;
                state_nxt = IDLE;
            end
            RESP: begin
                state_nxt = IDLE;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                if (err_q) begin
                    if_err = (owner == OWN_IF);
                    ls_err = (owner == OWN_LS);
                end else
`endif
                begin
                    if_rvalid = (owner == OWN_IF);
                    ls_rvalid = (owner == OWN_LS);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy = (state != IDLE);
        if (reset) begin
            busy      = 1'b0;
            mem_we    = 1'b0;
            if_rvalid = 1'b0;
            ls_rvalid = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            if_err    = 1'b0;
            ls_err    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner      <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            starve_cnt <= '0;
        end else begin
            if (gnt_if_c) begin
                owner <= OWN_IF;
                if (!misalign) begin
                    addr_q <= if_addr;
                end
            end else if (gnt_ls_c) begin
                owner <= OWN_LS;
                if (!misalign) begin
                    addr_q  <= ls_addr;
                    wdata_q <= ls_wdata;
                end
            end

            if (gnt_if_c) begin
                starve_cnt <= '0;
            end else if (gnt_ls_c) begin
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end

            if (state == RD_WAIT && wait_done) begin
                if (owner == OWN_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    ls_rdata_q <= mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (gnt_if_c || gnt_ls_c) begin
            err_q <= misalign;
        end
    end
`endif

    assign if_gnt    = gnt_if_c;
    assign ls_gnt    = gnt_ls_c;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        if_err, ls_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    // Memory contents: one fixed instruction word, everything else address-derived.
    assign mem_rdata = (mem_addr == 32'h10) ? 32'h8C22_0004 : (mem_addr ^ 32'h5A5A_0000);

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef MEM_ARB_ALIGN_CHECK_EN
        ,
        .if_err    (if_err),
        .ls_err    (ls_err)
`endif
    );

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        if_req = 1'b1; if_addr = 32'h10;
        sample();
        tests++; if (if_gnt !== 1'b0) begin fails++; $display("FAIL rst_if_gnt got=%b want=0", if_gnt); end
        tests++; if (ls_gnt !== 1'b0) begin fails++; $display("FAIL rst_ls_gnt got=%b want=0", ls_gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b want=0", busy); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        tests++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin fails++; $display("FAIL rst_rvalid got=%b want=00", {if_rvalid, ls_rvalid}); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
        tests++; if ((if_rdata | ls_rdata) !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h/%h want=0", if_rdata, ls_rdata); end
        if_req = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_if_fetch();
        logic exp;
        if_req = 1'b1; if_addr = 32'h10;
        sample();
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL fetch_gnt got=%b want=1", if_gnt); end
        tests++; if (ls_gnt !== 1'b0) begin fails++; $display("FAIL fetch_ls_gnt got=%b want=0", ls_gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fetch_busy_T got=%b want=0", busy); end
        next_cycle();
        if_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sample();
            exp = (k <= 3);
            tests++; if (busy !== exp) begin fails++; $display("FAIL fetch_busy_T+%0d got=%b want=%b", k, busy, exp); end
            exp = (k == 3);
            tests++; if (if_rvalid !== exp) begin fails++; $display("FAIL fetch_rvalid_T+%0d got=%b want=%b", k, if_rvalid, exp); end
            if (k == 1) begin
                tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL fetch_mem_addr got=%h want=10", mem_addr); end
            end
            if (k == 3) begin
                tests++; if (if_rdata !== 32'h8C22_0004) begin fails++; $display("FAIL fetch_rdata got=%h want=8c220004", if_rdata); end
            end
            next_cycle();
        end
    endtask

    task automatic test_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF;
        sample();
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL store_gnt got=%b want=1", ls_gnt); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL store_we_T got=%b want=0", mem_we); end
        next_cycle();
        ls_req = 1'b0; ls_we = 1'b0;
        sample();
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL store_we_T+1 got=%b want=1", mem_we); end
        tests++; if (mem_addr !== 32'h40) begin fails++; $display("FAIL store_addr got=%h want=40", mem_addr); end
        tests++; if (mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_wdata got=%h want=deadbeef", mem_wdata); end
        tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL store_rvalid_T+1 got=%b want=0", ls_rvalid); end
        next_cycle();
        for (int k = 2; k <= 3; k++) begin
            sample();
            tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL store_we_T+%0d got=%b want=0", k, mem_we); end
            tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL store_rvalid_T+%0d got=%b want=0", k, ls_rvalid); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL store_busy_T+%0d got=%b want=0", k, busy); end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic exp;
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
        sample();
        tests++; if ({if_gnt, ls_gnt} !== 2'b01) begin fails++; $display("FAIL cont_gnt got=%b want=01", {if_gnt, ls_gnt}); end
        next_cycle();
        ls_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sample();
            exp = (k == 4);
            tests++; if (if_gnt !== exp) begin fails++; $display("FAIL cont_if_gnt_T+%0d got=%b want=%b", k, if_gnt, exp); end
            exp = (k == 3);
            tests++; if (ls_rvalid !== exp) begin fails++; $display("FAIL cont_ls_rvalid_T+%0d got=%b want=%b", k, ls_rvalid, exp); end
            if (k == 3) begin
                tests++; if (ls_rdata !== 32'h5A5A_0044) begin fails++; $display("FAIL cont_ls_rdata got=%h want=5a5a0044", ls_rdata); end
            end
            next_cycle();
        end
        if_req = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            sample();
            exp = (k == 7);
            tests++; if (if_rvalid !== exp) begin fails++; $display("FAIL cont_if_rvalid_T+%0d got=%b want=%b", k, if_rvalid, exp); end
            if (k == 7) begin
                tests++; if (if_rdata !== 32'h5A5A_0020) begin fails++; $display("FAIL cont_if_rdata got=%h want=5a5a0020", if_rdata); end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h30;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h48;
        for (int a = 0; a < 10; a++) begin
            exp_if = (a == 4 || a == 9);
            sample();
            tests++; if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin fails++; $display("FAIL starve_arb%0d got=%b want=%b", a, {if_gnt, ls_gnt}, {exp_if, !exp_if}); end
            next_cycle(); next_cycle(); next_cycle();
            sample();
            if (exp_if) begin
                tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h5A5A_0030) begin fails++; $display("FAIL starve_if_resp%0d got=%b/%h want=1/5a5a0030", a, if_rvalid, if_rdata); end
            end else begin
                tests++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h5A5A_0048) begin fails++; $display("FAIL starve_ls_resp%0d got=%b/%h want=1/5a5a0048", a, ls_rvalid, ls_rdata); end
            end
            next_cycle();
        end
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic exp;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4C;
        sample();
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL abort_ld_gnt got=%b want=1", ls_gnt); end
        next_cycle();
        ls_req = 1'b0; reset = 1'b1;
        sample();
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL abort_ld_we got=%b want=0", mem_we); end
        next_cycle();
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h50;
        sample();
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL abort_if_gnt got=%b want=1", if_gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b want=0", busy); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL abort_mem_addr got=%h want=0", mem_addr); end
        tests++; if (ls_rdata !== 32'h0) begin fails++; $display("FAIL abort_ls_rdata got=%h want=0", ls_rdata); end
        next_cycle();
        if_req = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            sample();
            tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL abort_ls_rvalid_T+%0d got=%b want=0", k, ls_rvalid); end
            exp = (k == 5);
            tests++; if (if_rvalid !== exp) begin fails++; $display("FAIL abort_if_rvalid_T+%0d got=%b want=%b", k, if_rvalid, exp); end
            if (k == 5) begin
                tests++; if (if_rdata !== 32'h5A5A_0050) begin fails++; $display("FAIL abort_if_rdata got=%h want=5a5a0050", if_rdata); end
            end
            next_cycle();
        end
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h54; ls_wdata = 32'h1111_2222;
        sample();
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL abort_st_gnt got=%b want=1", ls_gnt); end
        next_cycle();
        ls_req = 1'b0; ls_we = 1'b0; reset = 1'b1;
        sample();
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL abort_st_we got=%b want=0", mem_we); end
        next_cycle();
        reset = 1'b0;
        sample();
        tests++; if ({busy, mem_we} !== 2'b00) begin fails++; $display("FAIL abort_st_idle got=%b want=00", {busy, mem_we}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h60; ls_wdata = 32'hCAFE_F00D;
        sample();
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL b2b_st_gnt got=%b want=1", ls_gnt); end
        next_cycle();
        ls_we = 1'b0; ls_addr = 32'h64;
        sample();
        tests++; if (ls_gnt !== 1'b0) begin fails++; $display("FAIL b2b_busy_gnt got=%b want=0", ls_gnt); end
        tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h60 || mem_wdata !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL b2b_write got=%b/%h/%h want=1/60/cafef00d", mem_we, mem_addr, mem_wdata); end
        next_cycle();
        sample();
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL b2b_ld_gnt got=%b want=1", ls_gnt); end
        next_cycle();
        ls_req = 1'b0;
        sample();
        tests++; if (mem_we !== 1'b0 || mem_addr !== 32'h64) begin fails++; $display("FAIL b2b_ld_addr got=%b/%h want=0/64", mem_we, mem_addr); end
        next_cycle();
        sample();
        tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL b2b_early_rvalid got=%b want=0", ls_rvalid); end
        next_cycle();
        sample();
        tests++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h5A5A_0064) begin fails++; $display("FAIL b2b_ld_resp got=%b/%h want=1/5a5a0064", ls_rvalid, ls_rdata); end
        next_cycle();
    endtask

`ifdef MEM_ARB_ALIGN_CHECK_EN
    task automatic test_align();
        for (int s = 0; s < 2; s++) begin
            ls_req = 1'b1; ls_we = (s == 1); ls_addr = (s == 1) ? 32'h43 : 32'h42;
            sample();
            tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL align%0d_gnt got=%b want=1", s, ls_gnt); end
            next_cycle();
            ls_req = 1'b0; ls_we = 1'b0;
            sample();
            tests++; if (ls_err !== 1'b1 || ls_rvalid !== 1'b0 || if_err !== 1'b0) begin
                fails++; $display("FAIL align%0d_err got=%b/%b/%b want=1/0/0", s, ls_err, ls_rvalid, if_err); end
            tests++; if (mem_we !== 1'b0 || mem_addr !== 32'h64) begin fails++; $display("FAIL align%0d_mem got=%b/%h want=0/64", s, mem_we, mem_addr); end
            next_cycle();
            sample();
            tests++; if (ls_err !== 1'b0 || busy !== 1'b0 || ls_rdata !== 32'h5A5A_0064) begin
                fails++; $display("FAIL align%0d_after got=%b/%b/%h want=0/0/5a5a0064", s, ls_err, busy, ls_rdata); end
            next_cycle();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_if_fetch();
        test_store();
        test_contention();
        test_starvation();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        test_align();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle CPU between two requesters: instruction fetch (IF) and load/store (LS).
- Owns the memory's fixed read wait states, so the control FSM no longer hard-codes WAIT/WAITLW states.
- Sits between the control unit / datapath (PC, ALUOut address sources) and the memory; drives the memory address, write data and WriteMem strobe.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles, ≥1; mem_rdata is valid MEM_LAT cycles after mem_addr is first presented
- STARVE_MAX, 4, consecutive LS grants allowed while if_req is pending before IF is forced; ≥1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level; held until if_gnt
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- ls_req  in  1  load/store request, level; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address (ALUOut)
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  LS accepted this cycle
- ls_rvalid  out  1  one-cycle pulse on load completion, ls_rdata valid
- ls_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe (WriteMem)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. Port names are clock and reset.
- States: IDLE, RD_WAIT, WR, RESP.
- Reset values: all outputs 0; state = IDLE; starvation counter = 0; latched address, data, owner and rdata registers = 0.
- Grant (IDLE only):
  - if_gnt/ls_gnt are combinational, one-hot, asserted only in IDLE.
  - Priority is LS over IF, unless the starvation counter equals STARVE_MAX and if_req = 1; then IF is granted.
  - On grant, latch addr, we, wdata and owner.
  - Next state: WR for an LS store, else RD_WAIT with the wait counter = 0.
- Starvation counter:
  - Increments on each LS grant made while if_req = 1.
  - Clears on any IF grant, or on any LS grant made while if_req = 0.
  - Saturates at STARVE_MAX.
- mem_addr and mem_wdata are driven from the latched registers. They are stable from the cycle after grant through the end of the transaction, and hold their last value in IDLE.
- RD_WAIT:
  - Counts MEM_LAT cycles.
  - In the last cycle, sample mem_rdata into the owner's rdata register, then go to RESP.
- RESP:
  - Exactly one cycle; pulses the owner's rvalid; next state IDLE.
  - Read latency: grant in cycle T → rvalid in cycle T+MEM_LAT+1. Next grant possible at T+MEM_LAT+2.
- WR:
  - mem_we = 1 for exactly one cycle (T+1), then IDLE.
  - No rvalid for stores.
  - mem_we is never asserted for IF.
- Requester timing:
  - Dropping req after gnt has no effect; the transaction completes.
  - req changes while busy are ignored until IDLE.
- Simultaneous if_req and ls_req: arbitration rule above. The loser stays pending, with no gnt.
- rdata registers hold their value until the next completion for the same owner.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all outputs 0.
  - No rvalid for the aborted access; mem_we is deasserted immediately on the reset cycle edge.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- When defined:
  - Adds output ports if_err and ls_err (1 bit each).
  - A granted request with addr[1:0] ≠ 0 does not access memory: mem_we stays 0 and mem_addr is not updated.
  - Goes directly to RESP; pulses the owner's err instead of rvalid; the owner's rdata is unchanged.
- When undefined: no err ports; the low address bits pass through unchecked.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, RD_WAIT, WR, RESP)
  - owner enum (OWN_IF, OWN_LS)
  - default ADDR_W, DATA_W, MEM_LAT, STARVE_MAX constants
- One sub-module: mem_wait_counter.
  - Parameterised by MEM_LAT.
  - Inputs: clock, reset, start.
  - Output: done, asserted in the MEM_LAT-th cycle after start.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, memory returns 0x8C22_0004 (MEM_LAT=2) → if_gnt at T; if_rvalid at T+3 with if_rdata=0x8C22_0004; busy high T+1..T+3.
- ls_req=1, ls_we=1, ls_addr=0x40, ls_wdata=0xDEAD_BEEF → ls_gnt at T; mem_we=1 only at T+1 with mem_addr=0x40, mem_wdata=0xDEAD_BEEF; no ls_rvalid.
- if_req and ls_req (load, 0x44) both asserted at T → ls_gnt at T, ls_rvalid at T+3; if_gnt at T+4.
- if_req held high, ls_req issues 5 back-to-back loads with STARVE_MAX=4 → the 5th arbitration grants IF; the counter clears to 0 after the IF grant.
- Load granted, reset asserted at T+1 → state IDLE at T+2; no ls_rvalid; mem_we=0 throughout; a new if_req is granted at T+2 after reset deasserts.
- With MEM_ARB_ALIGN_CHECK_EN: ls load at 0x42 → ls_err pulse at T+1; mem_addr unchanged; ls_rvalid never asserted.
